// File: rtl/i2c_eeprom_slave.sv
// I2C EEPROM-style slave: oversampled SCL/SDA, START/STOP/Sr decode,
// byte/page write with in-page wrap, current/random/sequential reads.
//
// Parameters: DEV_ADDR (7-bit address), ADDR_BYTES (1 or 2),
//             DEPTH (memory bytes), PAGE_SIZE (write page bytes).
// Ports:
//   clk     - system clock, at least 10x SCL
//   rst_n   - synchronous active-low reset
//   scl_i   - SCL pad input (asynchronous)
//   sda_i   - SDA pad input (asynchronous)
//   sda_oe  - 1 pulls SDA low, 0 releases it
//   busy    - high from an address-matched device byte to STOP/START
//   wp      - write protect, present only with I2C_EEPROM_WP_EN defined
// Optional feature macro: I2C_EEPROM_WP_EN (write-protect input).
module i2c_eeprom_slave #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         ADDR_BYTES = 2,
    parameter int         DEPTH      = 256,
    parameter int         PAGE_SIZE  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_oe,
    output logic busy
`ifdef I2C_EEPROM_WP_EN
    ,
    input  logic wp
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PMASK = AW'(PAGE_SIZE - 1);
    localparam logic ALAST = 1'(ADDR_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV, S_DEV_ACK, S_ADDR, S_ADDR_ACK,
        S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_IGNORE
    } state_t;

    state_t r_state, w_state_nxt;

    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;
    logic [7:0] r_shift;
    logic [3:0] r_bitcnt;
    logic [AW-1:0] r_ptr;
    logic [7:0] r_addr_hi;
    logic r_abyte;
    logic r_mack;
    logic r_sda_oe, r_busy;
    logic w_oe_nxt, w_busy_nxt;
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    logic w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
    logic w_start, w_stop, w_done, w_match, w_we, w_wp_ok;
    logic [AW-1:0] w_addr, w_ptr_page, w_ptr_inc;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_sda_rise = r_sda_s2 & ~r_sda_d;
    assign w_sda_fall = ~r_sda_s2 & r_sda_d;
    // SCL must be stably high on both sides of the SDA edge
    assign w_start = w_sda_fall & r_scl_s2 & r_scl_d;
    assign w_stop  = w_sda_rise & r_scl_s2 & r_scl_d;
    assign w_done  = (r_bitcnt == 4'd8);
    assign w_match = (r_shift[7:1] == DEV_ADDR);

    assign w_addr = (ADDR_BYTES == 2) ? AW'({r_addr_hi, r_shift})
                                      : AW'(r_shift);
    assign w_ptr_inc  = r_ptr + AW'(1);
    // only the in-page bits advance; the page base is kept
    assign w_ptr_page = (r_ptr & ~PMASK) | (w_ptr_inc & PMASK);

`ifdef I2C_EEPROM_WP_EN
    assign w_wp_ok = ~wp;
`else
    assign w_wp_ok = 1'b1;
`endif

    // the 8th rising edge of a write-data byte commits it
    assign w_we = (r_state == S_WR) && w_scl_rise &&
                  (r_bitcnt == 4'd7) && w_wp_ok;

    assign sda_oe = r_sda_oe;
    assign busy   = r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_i, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_i, r_sda_s1, r_sda_s2};
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = S_DEV;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_scl_fall) begin
            unique case (r_state)
                S_DEV:      if (w_done) w_state_nxt = w_match ? S_DEV_ACK : S_IGNORE;
                S_DEV_ACK:  w_state_nxt = r_shift[0] ? S_RD : S_ADDR;
                S_ADDR:     if (w_done) w_state_nxt = S_ADDR_ACK;
                S_ADDR_ACK: w_state_nxt = (r_abyte == ALAST) ? S_WR : S_ADDR;
                S_WR:       if (w_done) w_state_nxt = S_WR_ACK;
                S_WR_ACK:   w_state_nxt = S_WR;
                S_RD:       if (w_done) w_state_nxt = S_RD_ACK;
                S_RD_ACK:   w_state_nxt = r_mack ? S_IGNORE : S_RD;
                default:    w_state_nxt = r_state;
            endcase
        end
    end

    // output logic: next SDA drive and busy, registered below
    always_comb begin
        w_oe_nxt   = r_sda_oe;
        w_busy_nxt = r_busy;
        if (w_start || w_stop) begin
            w_oe_nxt   = 1'b0;
            w_busy_nxt = 1'b0;
        end else if (w_scl_fall) begin
            unique case (r_state)
                S_DEV: if (w_done && w_match) begin
                    w_oe_nxt   = 1'b1;
                    w_busy_nxt = 1'b1;
                end
                S_DEV_ACK:  w_oe_nxt = r_shift[0] & ~r_rdata[7];
                S_ADDR:     if (w_done) w_oe_nxt = 1'b1;
                S_ADDR_ACK: w_oe_nxt = 1'b0;
                S_WR:       if (w_done) w_oe_nxt = 1'b1;
                S_WR_ACK:   w_oe_nxt = 1'b0;
                S_RD:       w_oe_nxt = w_done ? 1'b0 : ~r_shift[6];
                S_RD_ACK:   w_oe_nxt = ~r_mack & ~r_rdata[7];
                default:    w_oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_sda_oe <= w_oe_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // datapath: shift register, bit counter, pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_ptr     <= '0;
            r_addr_hi <= '0;
            r_abyte   <= 1'b0;
            r_mack    <= 1'b1;
        end else if (w_start || w_stop) begin
            r_bitcnt <= '0;
            r_abyte  <= 1'b0;
        end else begin
            unique case (r_state)
                S_DEV, S_ADDR, S_WR: begin
                    if (w_scl_rise) begin
                        r_shift  <= {r_shift[6:0], r_sda_s2};
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end else if (w_scl_fall && w_done) begin
                        r_bitcnt <= '0;
                        if (r_state == S_WR) r_ptr <= w_ptr_page;
                        if (r_state == S_ADDR) begin
                            if (r_abyte == ALAST) r_ptr <= w_addr;
                            else                  r_addr_hi <= r_shift;
                        end
                    end
                end
                S_ADDR_ACK: if (w_scl_fall) r_abyte <= ~r_abyte;
                S_DEV_ACK: if (w_scl_fall && r_shift[0]) r_shift <= r_rdata;
                S_RD: begin
                    if (w_scl_rise) begin
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (w_done) r_bitcnt <= '0;
                        else        r_shift  <= {r_shift[6:0], 1'b0};
                    end
                end
                S_RD_ACK: begin
                    // advancing on the rise leaves the ACK low phase
                    // for the registered read of the next byte
                    if (w_scl_rise) begin
                        r_mack <= r_sda_s2;
                        r_ptr  <= w_ptr_inc;
                    end else if (w_scl_fall && !r_mack) begin
                        r_shift <= r_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_ptr] <= {r_shift[6:0], r_sda_s2};
        r_rdata <= r_mem[r_ptr];
    end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-level I2C master, byte-level memory
// model, per-bit compare of sda_oe/busy plus literal data checks.
module tb_i2c_eeprom_slave;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic sda_m = 1'b1;
    logic sda_oe, busy;
    wire  sda_bus = sda_m & ~sda_oe;
`ifdef I2C_EEPROM_WP_EN
    logic wp = 1'b0;
`endif

    always #5 clk = ~clk;

    i2c_eeprom_slave dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .scl_i  (scl),
        .sda_i  (sda_bus),
        .sda_oe (sda_oe),
        .busy   (busy)
`ifdef I2C_EEPROM_WP_EN
        ,
        .wp     (wp)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [256];
    bit         known [256];
    int         ptr_m = 0;
    bit         wp_m = 0;
    logic       exp_oe = 1'b0;
    logic       exp_busy = 1'b0;
    logic       exp_valid = 1'b0;
    logic [7:0] wq[$];
    logic [7:0] rq[$];
    event       ev_s;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // per-bit compare against the model's expected drive and busy
    always @(ev_s) begin
        if (exp_valid) chk("sda_oe", {15'd0, sda_oe}, {15'd0, exp_oe});
        chk("busy", {15'd0, busy}, {15'd0, exp_busy});
    end

    initial begin
        #900us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bit_cyc(input logic drv, input logic e_oe,
                           input logic e_val, output logic rd);
        sda_m = drv;
        clks(5);
        scl = 1'b1;
        clks(5);
        #1;
        exp_oe = e_oe;
        exp_valid = e_val;
        ->ev_s;
        rd = sda_bus;
        clks(5);
        scl = 1'b0;
        clks(5);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        clks(5);
        scl = 1'b1;
        clks(5);
        sda_m = 1'b0;
        clks(5);
        scl = 1'b0;
        exp_busy = 1'b0;
        clks(5);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        clks(5);
        scl = 1'b1;
        clks(5);
        sda_m = 1'b1;
        exp_busy = 1'b0;
        clks(5);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) bit_cyc(b[i], 1'b0, 1'b1, d);
        bit_cyc(1'b1, ack, 1'b1, d);
    endtask

    task automatic dev_byte(input logic [7:0] b, output logic m);
        logic d;
        m = (b[7:1] == 7'h50);
        for (int i = 7; i >= 0; i--) bit_cyc(b[i], 1'b0, 1'b1, d);
        exp_busy = m;
        bit_cyc(1'b1, m, 1'b1, d);
    endtask

    task automatic rd_byte(input logic [7:0] e, input logic v,
                           input logic mack, output logic [7:0] got);
        logic d;
        for (int i = 7; i >= 0; i--) begin
            bit_cyc(1'b1, ~e[i], v, d);
            got[i] = d;
        end
        bit_cyc(mack, 1'b0, 1'b1, d);
    endtask

    task automatic set_addr(input logic [15:0] a);
        wr_byte(a[15:8], 1'b1);
        wr_byte(a[7:0], 1'b1);
        ptr_m = int'(a[7:0]);
    endtask

    task automatic tx_write(input logic [7:0] dev, input logic [15:0] a);
        logic m;
        i2c_start();
        dev_byte(dev, m);
        if (!m) begin
            wr_byte(8'h5A, 1'b0);
            i2c_stop();
            return;
        end
        set_addr(a);
        foreach (wq[i]) begin
            wr_byte(wq[i], 1'b1);
            if (!wp_m) begin
                mem_m[ptr_m] = wq[i];
                known[ptr_m] = 1'b1;
            end
            ptr_m = (ptr_m & ~7) | ((ptr_m + 1) & 7);
        end
        i2c_stop();
    endtask

    task automatic tx_read(input bit with_addr, input logic [15:0] a,
                           input int n);
        logic m;
        logic [7:0] got;
        rq.delete();
        i2c_start();
        if (with_addr) begin
            dev_byte(8'hA0, m);
            set_addr(a);
            i2c_start();
        end
        dev_byte(8'hA1, m);
        for (int i = 0; i < n; i++) begin
            rd_byte(mem_m[ptr_m], known[ptr_m], (i == n - 1), got);
            rq.push_back(got);
            ptr_m = (ptr_m + 1) % 256;
        end
        i2c_stop();
    endtask

    initial begin
        logic [7:0] pexp [8];
        logic [7:0] fe_v, ff_v, dv;
        logic d;
        int op, n;

        for (int i = 0; i < 256; i++) begin
            mem_m[i] = 8'h00;
            known[i] = 1'b0;
        end
        clks(4);
        #1;
        chk("reset_oe", {15'd0, sda_oe}, 16'd0);
        chk("reset_busy", {15'd0, busy}, 16'd0);
        @(negedge clk) rst_n = 1'b1;
        clks(4);

        // byte write then random read
        wq = '{8'hAB};
        tx_write(8'hA0, 16'h0002);
        #1;
        chk("busy_after_stop", {15'd0, busy}, 16'd0);
        tx_read(1, 16'h0002, 1);
        chk("rand_read_AB", {8'd0, rq[0]}, 16'h00AB);

        // page write wrap from 0x0006
        wq.delete();
        for (int i = 0; i < 10; i++) wq.push_back(8'h11 + 8'(i));
        tx_write(8'hA0, 16'h0006);
        pexp = '{8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A};
        tx_read(1, 16'h0000, 8);
        for (int i = 0; i < 8; i++) chk("page_wrap", {8'd0, rq[i]}, {8'd0, pexp[i]});

        // sequential read wrapping 0xFF -> 0x00, then current address
        fe_v = 8'($urandom_range(0, 255));
        ff_v = 8'($urandom_range(0, 255));
        wq = '{fe_v, ff_v};
        tx_write(8'hA0, 16'h00FE);
        tx_read(1, 16'h00FE, 3);
        chk("seq_fe", {8'd0, rq[0]}, {8'd0, fe_v});
        chk("seq_ff", {8'd0, rq[1]}, {8'd0, ff_v});
        chk("seq_00", {8'd0, rq[2]}, 16'h0013);
        tx_read(0, 16'h0000, 1);
        chk("cur_addr_01", {8'd0, rq[0]}, 16'h0014);

        // address mismatch: NACK, no change, busy low
        tx_write(8'hB0, 16'h0000);
        #1;
        chk("mismatch_busy", {15'd0, busy}, 16'd0);
        tx_read(0, 16'h0000, 1);
        chk("mismatch_nochg", {8'd0, rq[0]}, 16'h0015);

        // reset in the middle of a read while SDA is pulled low
        wq = '{8'h00};
        tx_write(8'hA0, 16'h0020);
        i2c_start();
        dev_byte(8'hA0, d);
        set_addr(16'h0020);
        i2c_start();
        dev_byte(8'hA1, d);
        for (int i = 0; i < 3; i++) bit_cyc(1'b1, 1'b1, 1'b1, d);
        sda_m = 1'b1;
        clks(5);
        scl = 1'b1;
        clks(3);
        #1;
        chk("oe_before_rst", {15'd0, sda_oe}, 16'd1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("oe_after_rst", {15'd0, sda_oe}, 16'd0);
        chk("busy_after_rst", {15'd0, busy}, 16'd0);
        @(negedge clk) rst_n = 1'b1;
        ptr_m = 0;
        exp_busy = 1'b0;
        clks(5);
        scl = 1'b0;
        clks(5);
        tx_read(1, 16'h0005, 1);
        chk("read_after_rst", {8'd0, rq[0]}, 16'h0018);

`ifdef I2C_EEPROM_WP_EN
        wq = '{8'hAA};
        tx_write(8'hA0, 16'h0010);
        wp = 1'b1;
        wp_m = 1'b1;
        wq = '{8'h55};
        tx_write(8'hA0, 16'h0010);
        wp = 1'b0;
        wp_m = 1'b0;
        tx_read(1, 16'h0010, 1);
        chk("wp_keep_AA", {8'd0, rq[0]}, 16'h00AA);
`endif

        // randomized transactions against the model
        for (int it = 0; it < 14; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    wq.delete();
                    n = $urandom_range(1, 10);
                    for (int i = 0; i < n; i++) wq.push_back(8'($urandom_range(0, 255)));
                    tx_write(8'hA0, 16'($urandom));
                end
                1: tx_read(1, 16'($urandom), $urandom_range(1, 4));
                2: tx_read(0, 16'h0000, $urandom_range(1, 3));
                default: begin
                    dv = {7'h50 ^ 7'($urandom_range(1, 127)), 1'($urandom_range(0, 1))};
                    tx_write(dv, 16'h0000);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
